// File: rtl/wt_axi_txn_limiter.sv
// Outstanding-transaction limiter between the WT cache AXI master and the interconnect; all channels pass through
// combinationally, only AR/AW valid/ready are gated, and a held request stays pending upstream until admitted.
package ariane_axi;
   localparam int unsigned AddrWidth = 64;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned IdWidth   = 4;
   localparam int unsigned UserWidth = 1;

   typedef struct packed {
      logic [IdWidth-1:0]     id;
      logic [AddrWidth-1:0]   addr;
      logic [7:0]             len;
      logic [2:0]             size;
      logic [1:0]             burst;
      logic                   lock;
      logic [3:0]             cache;
      logic [2:0]             prot;
      logic [3:0]             qos;
      logic [3:0]             region;
      logic [5:0]             atop;
      logic [UserWidth-1:0]   user;
   } aw_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] strb;
      logic                   last;
      logic [UserWidth-1:0]   user;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]     id;
      logic [1:0]             resp;
      logic [UserWidth-1:0]   user;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]     id;
      logic [AddrWidth-1:0]   addr;
      logic [7:0]             len;
      logic [2:0]             size;
      logic [1:0]             burst;
      logic                   lock;
      logic [3:0]             cache;
      logic [2:0]             prot;
      logic [3:0]             qos;
      logic [3:0]             region;
      logic [UserWidth-1:0]   user;
   } ar_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]     id;
      logic [DataWidth-1:0]   data;
      logic [1:0]             resp;
      logic                   last;
      logic [UserWidth-1:0]   user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     ar_ready;
      logic     w_ready;
      logic     b_valid;
      b_chan_t  b;
      logic     r_valid;
      r_chan_t  r;
   } resp_t;
endpackage

module wt_axi_txn_limiter #(
   parameter int unsigned AxiAddrWidth = 64,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned AxiIdWidth   = 4,
   parameter int unsigned AxiUserWidth = 1,
   parameter type         axi_req_t    = ariane_axi::req_t,
   parameter type         axi_rsp_t    = ariane_axi::resp_t,
   parameter int unsigned MaxRdTxns    = 8,
   parameter int unsigned MaxWrTxns    = 8,
   localparam int unsigned RdCntW      = $clog2(MaxRdTxns + 1),
   localparam int unsigned WrCntW      = $clog2(MaxWrTxns + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              drain_i,
   input  axi_req_t          slv_req_i,
   output axi_rsp_t          slv_resp_o,
   output axi_req_t          mst_req_o,
   input  axi_rsp_t          mst_resp_i,
   output logic [RdCntW-1:0] rd_cnt_o,
   output logic [WrCntW-1:0] wr_cnt_o,
   output logic              idle_o,
   output logic              stall_o,
   output logic              err_o
);

   if (AxiAddrWidth == 0 || AxiDataWidth < 8 || AxiIdWidth == 0 || AxiUserWidth == 0 ||
       MaxRdTxns == 0 || MaxRdTxns > 255 || MaxWrTxns == 0 || MaxWrTxns > 255) begin : g_bad_params
      $error("wt_axi_txn_limiter: parameter out of range");
   end

   localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxRdTxns);
   localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWrTxns);

   logic [RdCntW-1:0] rd_cnt;
   logic [WrCntW-1:0] wr_cnt;
   logic              err;
   logic              ar_ok, aw_ok;
   logic              rd_inc, rd_dec, wr_inc, wr_dec;

   // Admission looks at the registered count only, so a freed slot is reusable one cycle later.
   assign ar_ok = ~drain_i & (rd_cnt < RdMax);
   assign aw_ok = ~drain_i & (wr_cnt < WrMax);

   always_comb begin
      mst_req_o           = slv_req_i;
      mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_ok;
      mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_ok;
      slv_resp_o          = mst_resp_i;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
   end

   assign rd_inc = mst_req_o.ar_valid & mst_resp_i.ar_ready;
   assign rd_dec = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
   assign wr_inc = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign wr_dec = mst_resp_i.b_valid & slv_req_i.b_ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (rd_inc && !rd_dec) begin
            rd_cnt <= rd_cnt + 1'b1;
         end else if (rd_dec && !rd_inc) begin
            if (rd_cnt == '0) err <= 1'b1;
            else              rd_cnt <= rd_cnt - 1'b1;
         end
         if (wr_inc && !wr_dec) begin
            wr_cnt <= wr_cnt + 1'b1;
         end else if (wr_dec && !wr_inc) begin
            if (wr_cnt == '0) err <= 1'b1;
            else              wr_cnt <= wr_cnt - 1'b1;
         end
      end
   end

   assign rd_cnt_o = rd_cnt;
   assign wr_cnt_o = wr_cnt;
   assign idle_o   = (rd_cnt == '0) & (wr_cnt == '0);
   assign stall_o  = (slv_req_i.ar_valid & ~ar_ok) | (slv_req_i.aw_valid & ~aw_ok);
   assign err_o    = err;

endmodule

// File: tb/tb_wt_axi_txn_limiter.sv
// Directed scenarios then random traffic, checked every cycle against a counting reference model.
module tb_wt_axi_txn_limiter;

   localparam int MAX_RD = 6;
   localparam int MAX_WR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic drain = 1'b0;
   ariane_axi::req_t  slv_req, mst_req;
   ariane_axi::resp_t slv_resp, mst_resp;
   logic [$clog2(MAX_RD+1)-1:0] rd_cnt;
   logic [$clog2(MAX_WR+1)-1:0] wr_cnt;
   logic idle, stall, err;

   int errors = 0;
   int checks = 0;
   int m_rd = 0;
   int m_wr = 0;
   bit m_err = 1'b0;

   always #5 clk = ~clk;

   wt_axi_txn_limiter #(
      .MaxRdTxns(MAX_RD),
      .MaxWrTxns(MAX_WR)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .drain_i    (drain),
      .slv_req_i  (slv_req),
      .slv_resp_o (slv_resp),
      .mst_req_o  (mst_req),
      .mst_resp_i (mst_resp),
      .rd_cnt_o   (rd_cnt),
      .wr_cnt_o   (wr_cnt),
      .idle_o     (idle),
      .stall_o    (stall),
      .err_o      (err)
   );

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      slv_req  = '0;
      mst_resp = '0;
      drain    = 1'b0;
      slv_req.r_ready = 1'b1;
      slv_req.b_ready = 1'b1;
   endtask

   // Compare every DUT output against what the current model state implies.
   task automatic check_all();
      ariane_axi::req_t  exp_req;
      ariane_axi::resp_t exp_rsp;
      bit ar_ok, aw_ok;
      ar_ok = !drain && (m_rd < MAX_RD);
      aw_ok = !drain && (m_wr < MAX_WR);
      exp_req = slv_req;
      exp_req.ar_valid = slv_req.ar_valid && ar_ok;
      exp_req.aw_valid = slv_req.aw_valid && aw_ok;
      exp_rsp = mst_resp;
      exp_rsp.ar_ready = mst_resp.ar_ready && ar_ok;
      exp_rsp.aw_ready = mst_resp.aw_ready && aw_ok;
      chk("mst_req",  320'(mst_req),  320'(exp_req));
      chk("slv_resp", 320'(slv_resp), 320'(exp_rsp));
      chk("rd_cnt",   320'(rd_cnt),   320'(m_rd));
      chk("wr_cnt",   320'(wr_cnt),   320'(m_wr));
      chk("idle",     320'(idle),     320'(m_rd == 0 && m_wr == 0));
      chk("stall",    320'(stall),    320'((slv_req.ar_valid && !ar_ok) || (slv_req.aw_valid && !aw_ok)));
      chk("err",      320'(err),      320'(m_err));
   endtask

   task automatic settle();
      #4;
      check_all();
   endtask

   // Apply the counting rules to this cycle's handshakes, then move to the next cycle.
   task automatic advance();
      bit ar_ok, aw_ok, ri, rdd, wi, wd;
      ar_ok = !drain && (m_rd < MAX_RD);
      aw_ok = !drain && (m_wr < MAX_WR);
      ri  = slv_req.ar_valid && ar_ok && mst_resp.ar_ready;
      rdd = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
      wi  = slv_req.aw_valid && aw_ok && mst_resp.aw_ready;
      wd  = mst_resp.b_valid && slv_req.b_ready;
      if (ri && !rdd) m_rd++;
      else if (rdd && !ri) begin
         if (m_rd == 0) m_err = 1'b1; else m_rd--;
      end
      if (wi && !wd) m_wr++;
      else if (wd && !wi) begin
         if (m_wr == 0) m_err = 1'b1; else m_wr--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   initial begin
      set_idle();
      // Reset state
      #2;
      check_all();
      chk("reset_idle", 320'(idle), 320'(1));
      chk("reset_rd_cnt", 320'(rd_cnt), 320'(0));
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      // Read limit: fill to MAX_RD, then the next AR is held
      slv_req.ar_valid   = 1'b1;
      mst_resp.ar_ready  = 1'b1;
      for (int i = 0; i < MAX_RD; i++) begin
         slv_req.ar.addr = {$urandom, $urandom};
         step();
      end
      settle();
      chk("ar_held_at_limit", 320'(mst_req.ar_valid), 320'(0));
      chk("stall_at_limit", 320'(stall), 320'(1));
      chk("rd_cnt_at_limit", 320'(rd_cnt), 320'(MAX_RD));
      advance();
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = 1'b1;
      settle();
      chk("ar_held_in_dec_cycle", 320'(mst_req.ar_valid), 320'(0));
      advance();
      mst_resp.r_valid = 1'b0;
      settle();
      chk("ar_admitted_after_dec", 320'(mst_req.ar_valid), 320'(1));
      chk("rd_cnt_after_dec", 320'(rd_cnt), 320'(MAX_RD - 1));
      advance();
      slv_req.ar_valid = 1'b0;
      settle();
      chk("rd_cnt_refilled", 320'(rd_cnt), 320'(MAX_RD));
      advance();

      mst_resp.r_valid = 1'b1;
      for (int i = 0; i < MAX_RD; i++) step();
      mst_resp.r_valid = 1'b0;
      settle();
      chk("rd_drained_idle", 320'(idle), 320'(1));
      advance();

      // Same-cycle AR handshake and R last at count 1
      slv_req.ar_valid = 1'b1;
      step();
      mst_resp.r_valid = 1'b1;
      step();
      slv_req.ar_valid = 1'b0;
      mst_resp.r_valid = 1'b0;
      settle();
      chk("rd_cnt_inc_dec", 320'(rd_cnt), 320'(1));
      advance();

      // Four-beat R burst, only the last beat retires it
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = 1'b0;
      for (int b = 0; b < 3; b++) begin
         mst_resp.r.data = {$urandom, $urandom};
         step();
      end
      settle();
      chk("rd_cnt_mid_burst", 320'(rd_cnt), 320'(1));
      advance();
      mst_resp.r.last = 1'b1;
      step();
      mst_resp.r_valid = 1'b0;
      settle();
      chk("rd_cnt_burst_done", 320'(rd_cnt), 320'(0));
      advance();

      // Write limit with B withheld; W keeps flowing
      slv_req.aw_valid  = 1'b1;
      slv_req.w_valid   = 1'b1;
      slv_req.w.last    = 1'b1;
      mst_resp.aw_ready = 1'b1;
      mst_resp.w_ready  = 1'b1;
      for (int i = 0; i < MAX_WR; i++) begin
         slv_req.w.data = {$urandom, $urandom};
         step();
      end
      settle();
      chk("aw_held_at_limit", 320'(mst_req.aw_valid), 320'(0));
      chk("w_passes_at_limit", 320'(mst_req.w_valid), 320'(1));
      chk("wr_cnt_at_limit", 320'(wr_cnt), 320'(MAX_WR));
      advance();
      slv_req.aw_valid  = 1'b0;
      slv_req.w_valid   = 1'b0;
      mst_resp.b_valid  = 1'b1;
      for (int i = 0; i < MAX_WR; i++) step();
      mst_resp.b_valid = 1'b0;
      settle();
      chk("wr_cnt_released", 320'(wr_cnt), 320'(0));
      chk("wr_idle", 320'(idle), 320'(1));
      advance();

      // Drain with three reads outstanding
      slv_req.ar_valid = 1'b1;
      for (int i = 0; i < 3; i++) step();
      drain = 1'b1;
      settle();
      chk("drain_blocks_ar", 320'(mst_req.ar_valid), 320'(0));
      chk("drain_not_idle", 320'(idle), 320'(0));
      advance();
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = 1'b1;
      for (int i = 0; i < 3; i++) step();
      mst_resp.r_valid = 1'b0;
      settle();
      chk("drain_idle", 320'(idle), 320'(1));
      advance();
      drain = 1'b0;
      settle();
      chk("undrain_forwards_ar", 320'(mst_req.ar_valid), 320'(1));
      advance();
      slv_req.ar_valid = 1'b0;
      mst_resp.r_valid = 1'b1;
      step();
      mst_resp.r_valid = 1'b0;

      // Spurious B at zero count
      mst_resp.b_valid = 1'b1;
      step();
      mst_resp.b_valid = 1'b0;
      settle();
      chk("err_set", 320'(err), 320'(1));
      chk("wr_cnt_no_underflow", 320'(wr_cnt), 320'(0));
      advance();
      step();
      settle();
      chk("err_sticky", 320'(err), 320'(1));
      advance();

      // Asynchronous reset mid-burst with five reads outstanding
      slv_req.ar_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = 1'b0;
      settle();
      chk("rd_cnt_before_reset", 320'(rd_cnt), 320'(5));
      rst = 1'b1;
      #1;
      chk("async_rst_rd_cnt", 320'(rd_cnt), 320'(0));
      chk("async_rst_err", 320'(err), 320'(0));
      chk("async_rst_idle", 320'(idle), 320'(1));
      m_rd  = 0;
      m_wr  = 0;
      m_err = 1'b0;
      set_idle();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         slv_req.ar_valid  = 1'($urandom_range(0, 1));
         slv_req.ar.addr   = {$urandom, $urandom};
         slv_req.ar.id     = 4'($urandom);
         slv_req.aw_valid  = 1'($urandom_range(0, 1));
         slv_req.aw.addr   = {$urandom, $urandom};
         slv_req.w_valid   = 1'($urandom_range(0, 1));
         slv_req.w.data    = {$urandom, $urandom};
         slv_req.w.last    = 1'($urandom_range(0, 1));
         slv_req.r_ready   = ($urandom_range(0, 9) < 8);
         slv_req.b_ready   = ($urandom_range(0, 9) < 8);
         mst_resp.ar_ready = ($urandom_range(0, 9) < 7);
         mst_resp.aw_ready = ($urandom_range(0, 9) < 7);
         mst_resp.w_ready  = 1'($urandom_range(0, 1));
         mst_resp.r_valid  = ($urandom_range(0, 9) < 4);
         mst_resp.r.last   = ($urandom_range(0, 2) == 0);
         mst_resp.r.data   = {$urandom, $urandom};
         mst_resp.b_valid  = ($urandom_range(0, 9) < 3);
         mst_resp.b.id     = 4'($urandom);
         drain             = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
